// File: rtl/dilithium_pkg.sv
// rtl/dilithium_pkg.sv - Shared Dilithium constants, zeta table and INTT state encoding
package dilithium_pkg;

    localparam int unsigned DIL_Q     = 32'd8380417;
    localparam int unsigned DIL_N_INV = 32'd8347681;
    localparam int unsigned ZETA_ROOT = 32'd1753;

    typedef logic [255:0][22:0] zeta_tab_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STAGE,
        ST_STORE,
        ST_DONE
    } intt_state_e;

    // zeta[k] = ZETA_ROOT^bitrev8(k) mod q, the order the forward NTT consumes them
    function automatic zeta_tab_t gen_zetas();
        zeta_tab_t       pw;
        zeta_tab_t       zt;
        longint unsigned acc;
        logic [7:0]      fwd;
        logic [7:0]      rev;
        acc = 64'd1;
        for (int e = 0; e < 256; e++) begin
            pw[e] = acc[22:0];
            acc   = (acc * 64'(ZETA_ROOT)) % 64'(DIL_Q);
        end
        for (int k = 0; k < 256; k++) begin
            fwd   = k[7:0];
            rev   = {<<{fwd}};
            zt[k] = pw[rev];
        end
        return zt;
    endfunction

    localparam zeta_tab_t ZETAS = gen_zetas();

endpackage

// File: rtl/mod_mul_q.sv
// rtl/mod_mul_q.sv - Single-cycle combinational 23x23 multiply reduced mod Q
module mod_mul_q
    import dilithium_pkg::*;
#(
    parameter int unsigned Q = DIL_Q
) (
    input  logic [22:0] a_i,
    input  logic [22:0] b_i,
    output logic [22:0] p_o
);

    logic [45:0] prod;

    assign prod = 46'(a_i) * 46'(b_i);
    assign p_o  = 23'(prod % 46'(Q));

endmodule

// File: rtl/intt_fsm.sv
// rtl/intt_fsm.sv - 256-point Dilithium inverse NTT, one Gentleman-Sande butterfly per cycle
// Optional INTT_SCALE_EN: multiply each STORE output by N_INV (256^-1 mod Q).
module intt_fsm
    import dilithium_pkg::*;
#(
    parameter int unsigned Q     = DIL_Q,
    parameter int unsigned N_INV = DIL_N_INV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [22:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [22:0] out_data,
    output logic [7:0]  out_index,
    output logic        busy,
    output logic        done
);

    localparam logic [22:0] Q23 = 23'(Q);
    localparam logic [23:0] Q24 = 24'(Q);

    if (N_INV >= Q || Q >= 32'd8388608) begin : g_bad_cfg
        $error("intt_fsm: Q must fit in 23 bits and N_INV must be below Q");
    end

    intt_state_e state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [2:0]  stage_q, stage_d;
    logic [6:0]  bf_q, bf_d;
    logic [7:0]  k_q, k_d;
    logic [22:0] mem_q [256];

    logic        in_fire;
    logic [6:0]  len_mask;
    logic [7:0]  j_lo, j_hi;
    logic [22:0] a_v, b_v, in_red, sum_v, diff_v, tw, prod_v, coef_v;
    logic [23:0] sum_w;

    assign in_fire = (state_q == ST_LOAD) && in_valid;

    // j = block*2*len + offset: block bits of bf move up one place to leave room for the len bit
    always_comb begin
        len_mask = 7'((8'd1 << stage_q) - 8'd1);
        j_lo     = {bf_q & ~len_mask, 1'b0} | {1'b0, bf_q & len_mask};
        j_hi     = j_lo | (8'd1 << stage_q);
    end

    assign in_red = (in_data >= Q23) ? in_data - Q23 : in_data;
    assign a_v    = mem_q[j_lo];
    assign b_v    = mem_q[j_hi];
    assign sum_w  = {1'b0, a_v} + {1'b0, b_v};
    assign sum_v  = (sum_w >= Q24) ? 23'(sum_w - Q24) : sum_w[22:0];
    assign diff_v = (a_v >= b_v) ? a_v - b_v : 23'({1'b0, a_v} + Q24 - {1'b0, b_v});
    assign tw     = 23'(Q - 32'(ZETAS[k_q]));

    mod_mul_q #(.Q(Q)) u_bf_mul (
        .a_i (tw),
        .b_i (diff_v),
        .p_o (prod_v)
    );

`ifdef INTT_SCALE_EN
    mod_mul_q #(.Q(Q)) u_scale_mul (
        .a_i (mem_q[idx_q]),
        .b_i (23'(N_INV)),
        .p_o (coef_v)
    );
`else
    assign coef_v = mem_q[idx_q];
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        bf_d    = bf_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = 8'd0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'd255) begin
                        state_d = ST_STAGE;
                        stage_d = 3'd0;
                        bf_d    = 7'd0;
                        k_d     = 8'd255;
                    end
                end
            end
            ST_STAGE: begin
                bf_d = bf_q + 7'd1;
                // one twiddle per start block: step k after the block's last butterfly
                if ((bf_q & len_mask) == len_mask) begin
                    k_d = k_q - 8'd1;
                end
                if (bf_q == 7'd127) begin
                    stage_d = stage_q + 3'd1;
                    if (stage_q == 3'd7) begin
                        state_d = ST_STORE;
                        idx_d   = 8'd0;
                    end
                end
            end
            ST_STORE: begin
                if (out_ready) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'd255) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'd0;
            stage_q <= 3'd0;
            bf_q    <= 7'd0;
            k_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            bf_q    <= bf_d;
            k_q     <= k_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[idx_q] <= in_red;
        end
        if (state_q == ST_STAGE) begin
            mem_q[j_lo] <= sum_v;
            mem_q[j_hi] <= prod_v;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_STORE);
    assign out_data  = out_valid ? coef_v : 23'd0;
    assign out_index = out_valid ? idx_q : 8'd0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_intt_fsm.sv
// tb/tb_intt_fsm.sv - Directed bench for intt_fsm; expectations follow INTT_SCALE_EN when defined
module tb_intt_fsm;

    localparam longint unsigned QM = 64'd8380417;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [22:0] in_data = 23'd0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, busy, done;
    logic [22:0] out_data;
    logic [7:0]  out_index;

    int n_cmp = 0;
    int n_err = 0;

    logic [22:0]     in_vec  [256];
    logic [22:0]     exp_vec [256];
    longint unsigned zt      [256];
    longint unsigned orig    [256];
    longint unsigned poly    [256];

    intt_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_out_data"},  32'(out_data),  32'd0);
        check_eq({tag, "_out_index"}, 32'(out_index), 32'd0);
        check_eq({tag, "_busy"},      32'(busy),      32'd0);
        check_eq({tag, "_done"},      32'(done),      32'd0);
    endtask

    task automatic init_zetas();
        longint unsigned pw [256];
        longint unsigned acc;
        int              rev;
        acc = 1;
        for (int e = 0; e < 256; e++) begin
            pw[e] = acc;
            acc   = (acc * 64'd1753) % QM;
        end
        for (int k = 0; k < 256; k++) begin
            rev = 0;
            for (int b = 0; b < 8; b++) begin
                if (((k >> b) & 1) != 0) rev = rev | (1 << (7 - b));
            end
            zt[k] = pw[rev];
        end
    endtask

    // Reference Cooley-Tukey forward NTT on poly[]
    task automatic fwd_ntt();
        int              k;
        longint unsigned z, t;
        k = 0;
        for (int len = 128; len > 0; len = len >> 1) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
                k++;
                z = zt[k];
                for (int j = st; j < st + len; j++) begin
                    t             = (z * poly[j + len]) % QM;
                    poly[j + len] = (poly[j] + QM - t) % QM;
                    poly[j]       = (poly[j] + t) % QM;
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_vec(input bit gaps);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < 256 && guard < 1000) begin
            in_valid = gaps ? (guard % 2 == 0) : 1'b1;
            in_data  = in_vec[i];
            acc      = in_valid && in_ready;
            guard++;
            @(negedge clk);
            if (acc) i++;
        end
        in_valid = 1'b0;
        check_eq("load_count", 32'(i), 32'd256);
    endtask

    task automatic wait_store(input bit inject);
        int cyc = 0;
        while (!out_valid && cyc < 2000) begin
            if (inject && cyc == 100) begin
                start    = 1'b1;
                in_valid = 1'b1;
                in_data  = 23'd5;
            end else begin
                start    = 1'b0;
                in_valid = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check_eq("stage_cycles", 32'(cyc), 32'd1024);
    endtask

    task automatic unload(input string tag, input bit stall);
        int  i = 0;
        int  guard = 0;
        int  stall_left = stall ? 5 : 0;
        bit  rdy;
        while (i < 256 && guard < 600) begin
            rdy = !(i == 10 && stall_left > 0);
            if (!rdy) stall_left--;
            out_ready = rdy;
            check_eq($sformatf("%s_ctl[%0d]", tag, i), 32'({out_valid, done, busy}), 32'b101);
            check_eq($sformatf("%s_idx[%0d]", tag, i), 32'(out_index), 32'(i));
            check_eq($sformatf("%s_data[%0d]", tag, i), 32'(out_data), 32'(exp_vec[i]));
            guard++;
            @(negedge clk);
            if (rdy) i++;
        end
        out_ready = 1'b0;
        check_eq({tag, "_count"}, 32'(i), 32'd256);
        check_eq({tag, "_done_ctl"}, 32'({out_valid, done, busy}), 32'b011);
        @(negedge clk);
        check_eq({tag, "_idle_ctl"}, 32'({out_valid, done, busy}), 32'b000);
    endtask

    task automatic fill(input logic [22:0] v, input logic [22:0] e0, input logic [22:0] erest);
        for (int i = 0; i < 256; i++) begin
            in_vec[i]  = v;
            exp_vec[i] = (i == 0) ? e0 : erest;
        end
    endtask

    initial begin
        init_zetas();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // all zero
        fill(23'd0, 23'd0, 23'd0);
        pulse_start();
        load_vec(1'b0);
        wait_store(1'b0);
        unload("zero", 1'b0);

        // every word equals Q; stray start/in_valid during STAGE must be ignored
        fill(23'd8380417, 23'd0, 23'd0);
        pulse_start();
        load_vec(1'b0);
        wait_store(1'b1);
        unload("allq", 1'b0);

        // constant 3 (entered as Q+3) is the transform of 3*x^0
`ifdef INTT_SCALE_EN
        fill(23'd8380420, 23'd3, 23'd0);
`else
        fill(23'd8380420, 23'd768, 23'd0);
`endif
        pulse_start();
        load_vec(1'b0);
        wait_store(1'b0);
        unload("const3", 1'b0);

        // round trip through the reference forward NTT, gapped load, stalled unload
        for (int i = 0; i < 256; i++) begin
            orig[i] = 64'($urandom_range(0, 32'd8380416));
            poly[i] = orig[i];
        end
        fwd_ntt();
        for (int i = 0; i < 256; i++) begin
            in_vec[i] = poly[i][22:0];
`ifdef INTT_SCALE_EN
            exp_vec[i] = orig[i][22:0];
`else
            exp_vec[i] = 23'((orig[i] * 64'd256) % QM);
`endif
        end
        pulse_start();
        load_vec(1'b1);
        wait_store(1'b0);
        unload("rtrip", 1'b1);

        // reset at STAGE cycle 500, then a clean zero transform
        fill(23'd1, 23'd0, 23'd0);
        pulse_start();
        load_vec(1'b0);
        repeat (500) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_rst_rel");
        fill(23'd0, 23'd0, 23'd0);
        pulse_start();
        load_vec(1'b0);
        wait_store(1'b0);
        unload("after_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
